key_token_decoder: RTL and testbench



---
 rtl/calc_pkg.sv | 56 +++++
 rtl/token_fifo.sv | 73 +++++++
 rtl/key_token_decoder.sv | 73 +++++++
 tb/tb_key_token_decoder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: token codes, PS/2 scan codes and the scan-to-token decode.
// Used by key_token_decoder and by the calculator FSM downstream.
package calc_pkg;

    localparam logic [3:0] TOK_ADD   = 4'd10;
    localparam logic [3:0] TOK_SUB   = 4'd11;
    localparam logic [3:0] TOK_MUL   = 4'd12;
    localparam logic [3:0] TOK_ENTER = 4'd13;
    localparam logic [3:0] TOK_CLEAR = 4'd14;

    // Index i of each table is the scan code of digit i.
    localparam logic [8:0] SC_ROW_DIGIT [10] = '{
        9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
        9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046
    };
    localparam logic [8:0] SC_PAD_DIGIT [10] = '{
        9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
        9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D
    };

    localparam logic [8:0] SC_KP_PLUS  = 9'h079;
    localparam logic [8:0] SC_KP_MINUS = 9'h07B;
    localparam logic [8:0] SC_MINUS    = 9'h04E;
    localparam logic [8:0] SC_KP_STAR  = 9'h07C;
    localparam logic [8:0] SC_ENTER    = 9'h05A;
    localparam logic [8:0] SC_KP_ENTER = 9'h15A;
    localparam logic [8:0] SC_ESC      = 9'h076;
    localparam logic [8:0] SC_BKSP     = 9'h066;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } tok_dec_t;

    function automatic tok_dec_t decode_scan(input logic [8:0] sc);
        tok_dec_t dec;
        dec.valid = 1'b0;
        dec.code  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (sc == SC_ROW_DIGIT[i] || sc == SC_PAD_DIGIT[i]) begin
                dec.valid = 1'b1;
                dec.code  = 4'(i);
            end
        end
        case (sc)
            SC_KP_PLUS:             begin dec.valid = 1'b1; dec.code = TOK_ADD;   end
            SC_KP_MINUS, SC_MINUS:  begin dec.valid = 1'b1; dec.code = TOK_SUB;   end
            SC_KP_STAR:             begin dec.valid = 1'b1; dec.code = TOK_MUL;   end
            SC_ENTER, SC_KP_ENTER:  begin dec.valid = 1'b1; dec.code = TOK_ENTER; end
            SC_ESC, SC_BKSP:        begin dec.valid = 1'b1; dec.code = TOK_CLEAR; end
            default: ;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/token_fifo.sv
// First-word fall-through token FIFO with occupancy count and a sticky overflow flag.
// DEPTH must be a power of two so the pointers wrap naturally.
module token_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [3:0]       push_code,
    input  logic             pop_ready,
    output logic             out_valid,
    output logic [3:0]       out_code,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]       mem_q [DEPTH];
    logic [3:0]       mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             empty, full, do_push, do_pop;

    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = !empty && pop_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_code;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        ovf_d   = ovf_q || (push && !do_push);
    end

    // NOTE: storage is reset too, so no stale token survives rst_n; it is only DEPTH x 4 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = !empty;
    assign out_code  = empty ? 4'd0 : mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/key_token_decoder.sv
// Turns KeyboardDecoder's held-key view into one calculator token per key press,
// queued in a token_fifo for the calculator FSM.
module key_token_decoder
    import calc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [511:0]     key_down,
    input  logic [8:0]       last_change,
    input  logic             tok_ready,
    output logic             tok_valid,
    output logic [3:0]       tok_code,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);

    logic       cur_q, cur_d, prev_cur_q, prev_cur_d;
    logic [8:0] lc_q, lc_d, prev_lc_q, prev_lc_d;
    logic       dec_valid_q, dec_valid_d;
    logic [3:0] dec_code_q, dec_code_d;
    logic       press;
    tok_dec_t   dec;

    always_comb begin
        cur_d      = key_down[last_change];
        lc_d       = last_change;
        prev_cur_d = cur_q;
        prev_lc_d  = lc_q;
        // A change of last_change while the new key is down is a rollover press.
        press       = cur_q && (!prev_cur_q || (lc_q != prev_lc_q));
        dec         = decode_scan(lc_q);
        dec_valid_d = press && dec.valid;
        dec_code_d  = dec.code;
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q       <= 1'b0;
            lc_q        <= '0;
            prev_cur_q  <= 1'b0;
            prev_lc_q   <= '0;
            dec_valid_q <= 1'b0;
            dec_code_q  <= '0;
        end else begin
            cur_q       <= cur_d;
            lc_q        <= lc_d;
            prev_cur_q  <= prev_cur_d;
            prev_lc_q   <= prev_lc_d;
            dec_valid_q <= dec_valid_d;
            dec_code_q  <= dec_code_d;
        end
    end

    token_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (dec_valid_q),
        .push_code (dec_code_q),
        .pop_ready (tok_ready),
        .out_valid (tok_valid),
        .out_code  (tok_code),
        .count     (fifo_count),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_key_token_decoder.sv
// Self-checking bench for key_token_decoder: decode table, directed corner cases and
// randomized traffic compared against a queue-based reference model.
module tb_key_token_decoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [511:0]     key_down;
    logic [8:0]       last_change;
    logic             tok_ready;
    logic             tok_valid;
    logic [3:0]       tok_code;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    always #5 clk = ~clk;

    key_token_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_down    (key_down),
        .last_change (last_change),
        .tok_ready   (tok_ready),
        .tok_valid   (tok_valid),
        .tok_code    (tok_code),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int dec_model(input logic [8:0] sc);
        case (sc)
            9'h045, 9'h070: return 0;
            9'h016, 9'h069: return 1;
            9'h01E, 9'h072: return 2;
            9'h026, 9'h07A: return 3;
            9'h025, 9'h06B: return 4;
            9'h02E, 9'h073: return 5;
            9'h036, 9'h074: return 6;
            9'h03D, 9'h06C: return 7;
            9'h03E, 9'h075: return 8;
            9'h046, 9'h07D: return 9;
            9'h079:         return 10;
            9'h07B, 9'h04E: return 11;
            9'h07C:         return 12;
            9'h05A, 9'h15A: return 13;
            9'h076, 9'h066: return 14;
            default:        return -1;
        endcase
    endfunction

    bit         model_on = 1'b0;
    bit         m_prev_cur;
    logic [8:0] m_prev_lc;
    bit         d1_v, d2_v;
    logic [3:0] d1_c, d2_c;
    logic [3:0] mq[$];
    bit         m_ovf;
    logic [3:0] got[$];

    task automatic model_reset();
        m_prev_cur = 1'b0;
        m_prev_lc  = '0;
        d1_v = 1'b0; d2_v = 1'b0;
        d1_c = '0;   d2_c = '0;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    // One clock edge: a press seen at edge n is pushed into the queue at edge n+2.
    task automatic model_step();
        bit cur, ev, pop, was_full;
        int t;
        cur      = key_down[last_change];
        ev       = cur && (!m_prev_cur || last_change != m_prev_lc);
        t        = dec_model(last_change);
        was_full = (mq.size() == DEPTH);
        pop      = (mq.size() > 0) && tok_ready;
        if (pop) void'(mq.pop_front());
        if (d2_v) begin
            if (was_full && !pop) m_ovf = 1'b1;
            else mq.push_back(d2_c);
        end
        d2_v = d1_v; d2_c = d1_c;
        d1_v = ev && (t >= 0);
        d1_c = (t >= 0) ? 4'(t) : 4'd0;
        m_prev_cur = cur;
        m_prev_lc  = last_change;
    endtask

    // Inputs are driven right after tick returns; outputs are compared 1 ns after the edge.
    task automatic tick();
        logic [8:0] exp_v;
        logic [3:0] head;
        if (tok_valid && tok_ready) got.push_back(tok_code);
        @(posedge clk);
        if (model_on) model_step();
        #1;
        if (model_on) begin
            head  = (mq.size() > 0) ? mq[0] : 4'd0;
            exp_v = {mq.size() > 0, head, CNT_W'(mq.size()), m_ovf};
            check("model", {tok_valid, tok_code, fifo_count, overflow}, exp_v);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_on = 1'b1;
    endtask

    task automatic press(input logic [8:0] sc);
        key_down[sc] = 1'b1;
        last_change  = sc;
        ticks(2);
        key_down[sc] = 1'b0;
        ticks(2);
    endtask

    typedef struct {
        logic [8:0] sc;
        bit         exp_v;
        logic [3:0] exp_c;
    } vec_t;

    vec_t vecs[$];

    logic [8:0] pool [12] = '{9'h045, 9'h016, 9'h069, 9'h079, 9'h07B, 9'h07C,
                              9'h05A, 9'h15A, 9'h076, 9'h01C, 9'h175, 9'h04E};

    initial begin
        vecs.push_back('{9'h045, 1'b1, 4'd0});
        vecs.push_back('{9'h016, 1'b1, 4'd1});
        vecs.push_back('{9'h046, 1'b1, 4'd9});
        vecs.push_back('{9'h070, 1'b1, 4'd0});
        vecs.push_back('{9'h07D, 1'b1, 4'd9});
        vecs.push_back('{9'h06C, 1'b1, 4'd7});
        vecs.push_back('{9'h079, 1'b1, 4'd10});
        vecs.push_back('{9'h07B, 1'b1, 4'd11});
        vecs.push_back('{9'h04E, 1'b1, 4'd11});
        vecs.push_back('{9'h07C, 1'b1, 4'd12});
        vecs.push_back('{9'h05A, 1'b1, 4'd13});
        vecs.push_back('{9'h15A, 1'b1, 4'd13});
        vecs.push_back('{9'h076, 1'b1, 4'd14});
        vecs.push_back('{9'h066, 1'b1, 4'd14});
        vecs.push_back('{9'h01C, 1'b0, 4'd0});
        vecs.push_back('{9'h175, 1'b0, 4'd0});
        vecs.push_back('{9'h179, 1'b0, 4'd0});

        key_down    = '0;
        last_change = '0;
        tok_ready   = 1'b1;
        rst_n       = 1'b1;
        #2;
        do_reset();
        check("reset_valid", tok_valid, 0);
        check("reset_code", tok_code, 0);
        check("reset_count", fifo_count, 0);
        check("reset_ovf", overflow, 0);

        // Single press held 50 cycles: one token, two-edge latency after sampling.
        got.delete();
        key_down[9'h016] = 1'b1;
        last_change      = 9'h016;
        tick();
        check("lat_edge_k", tok_valid, 0);
        tick();
        check("lat_edge_k1", tok_valid, 0);
        tick();
        check("lat_edge_k2_valid", tok_valid, 1);
        check("lat_edge_k2_code", tok_code, 1);
        ticks(47);
        key_down[9'h016] = 1'b0;
        ticks(5);
        check("hold_one_token", got.size(), 1);
        if (got.size() > 0) check("hold_code", got[0], 1);
        check("hold_count_empty", fifo_count, 0);

        // Fill to four with the consumer stalled, then drain one per cycle.
        tok_ready = 1'b0;
        press(9'h069); press(9'h079); press(9'h072); press(9'h05A);
        ticks(3);
        check("fill_count", fifo_count, 4);
        got.delete();
        tok_ready = 1'b1;
        ticks(4);
        check("drain_n", got.size(), 4);
        if (got.size() == 4) begin
            check("drain_0", got[0], 1);
            check("drain_1", got[1], 10);
            check("drain_2", got[2], 2);
            check("drain_3", got[3], 13);
        end
        check("drain_ovf", overflow, 0);

        // Rollover: 0x1E held, 0x26 pressed on top, then both released.
        got.delete();
        key_down[9'h01E] = 1'b1; last_change = 9'h01E; ticks(5);
        key_down[9'h026] = 1'b1; last_change = 9'h026; ticks(5);
        key_down[9'h026] = 1'b0; ticks(3);
        key_down[9'h01E] = 1'b0; last_change = 9'h01E; ticks(6);
        check("roll_n", got.size(), 2);
        if (got.size() == 2) begin
            check("roll_0", got[0], 2);
            check("roll_1", got[1], 3);
        end

        // Full FIFO with a push and pop on the same edge.
        tok_ready = 1'b0;
        press(9'h016); press(9'h01E); press(9'h026); press(9'h025);
        ticks(3);
        check("full_count", fifo_count, 4);
        key_down[9'h02E] = 1'b1; last_change = 9'h02E;
        ticks(2);
        got.delete();
        tok_ready = 1'b1;
        tick();
        check("pushpop_count", fifo_count, 4);
        check("pushpop_ovf", overflow, 0);
        key_down[9'h02E] = 1'b0;
        ticks(5);
        check("pushpop_n", got.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) check("pushpop_order", got[i], i + 1);
        end

        // Overflow: fifth token dropped, sticky flag.
        do_reset();
        tok_ready = 1'b0;
        press(9'h045); press(9'h016); press(9'h01E); press(9'h026); press(9'h025);
        ticks(3);
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        got.delete();
        tok_ready = 1'b1;
        ticks(5);
        check("ovf_drain_n", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) check("ovf_drain", got[i], i);
        end
        check("ovf_sticky", overflow, 1);

        // Unmapped and extended-unmapped codes produce nothing.
        got.delete();
        press(9'h01C); press(9'h175);
        ticks(3);
        check("unmapped_none", got.size(), 0);

        // Asynchronous reset with three tokens queued and overflow set.
        tok_ready = 1'b0;
        press(9'h016); press(9'h01E); press(9'h026);
        ticks(3);
        check("pre_rst_count", fifo_count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", tok_valid, 0);
        check("async_rst_count", fifo_count, 0);
        check("async_rst_ovf", overflow, 0);
        check("async_rst_code", tok_code, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Decode table.
        tok_ready = 1'b1;
        foreach (vecs[v]) begin
            got.delete();
            key_down[vecs[v].sc] = 1'b1;
            last_change          = vecs[v].sc;
            ticks(3);
            check($sformatf("vec_%03h", vecs[v].sc), {tok_valid, tok_code},
                  vecs[v].exp_v ? {1'b1, vecs[v].exp_c} : 5'd0);
            key_down[vecs[v].sc] = 1'b0;
            ticks(3);
            check($sformatf("vec_%03h_n", vecs[v].sc), got.size(), vecs[v].exp_v ? 1 : 0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [8:0] sc;
                sc = pool[$urandom_range(0, 11)];
                key_down[sc] = ~key_down[sc];
                last_change  = sc;
            end
            tok_ready = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
